// File: rtl/w0rm_data_bus_bridge.sv
// ---------------------------------------------------------------------------
// w0rm_data_bus_bridge
//
// Routes single-beat core read/write requests either to a synchronous RAM or
// to a handshaked IO space, selected by address (>= IO_BASE goes to IO).
// One request is in flight at a time; the core sees exactly one completion
// pulse per accepted request, optionally flagged as a bus error.
//
// Ports
//   core_clk, reset          : clock (rising edge) and synchronous active-high reset
//   core_addr_i/core_data_i  : request address and write data
//   core_read_i/core_write_i : request direction (exactly one must be set)
//   core_valid_i             : request strobe, only honoured while idle
//   core_data_o              : read data, held until the next completion
//   core_valid_o             : one-cycle completion pulse
//   ready_o                  : high while idle and able to accept a request
//   bus_error_o              : accompanies core_valid_o on a failed request
//   ram_*                    : one-cycle enable to a synchronous RAM
//   io_*                     : level strobes held until io_ack_i or timeout
// ---------------------------------------------------------------------------
module w0rm_data_bus_bridge #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    RAM_WAIT   = 1,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 32'hFFFF_0000,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_data_i,
    input  logic                  core_read_i,
    input  logic                  core_write_i,
    input  logic                  core_valid_i,
    output logic [DATA_WIDTH-1:0] core_data_o,
    output logic                  core_valid_o,
    output logic                  ready_o,
    output logic                  bus_error_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  io_read_o,
    output logic                  io_write_o,
    output logic [ADDR_WIDTH-1:0] io_addr_o,
    output logic [DATA_WIDTH-1:0] io_data_o,
    input  logic [DATA_WIDTH-1:0] io_data_i,
    input  logic                  io_ack_i
);

    localparam logic [1:0] STATE_IDLE     = 2'd0;
    localparam logic [1:0] STATE_RAM_WAIT = 2'd1;
    localparam logic [1:0] STATE_IO_WAIT  = 2'd2;
    localparam logic [1:0] STATE_RESPOND  = 2'd3;

    // Counter value seen at the edge that completes each kind of access.
    // The counter reads 0 during the RAM enable cycle, so a read finishes
    // RAM_WAIT edges later and a write one edge later. For IO the edge
    // that would make the count reach TIMEOUT is the timeout edge.
    localparam logic [7:0] RAM_RD_LAST = 8'(RAM_WAIT);
    localparam logic [7:0] RAM_WR_LAST = 8'd1;
    localparam logic [7:0] IO_LAST     = 8'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Next-state logic. The request is latched only at acceptance so that
    // later core input activity cannot disturb an access in flight. Any
    // path into RESPOND also sets the read data and error flag it reports.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            STATE_IDLE: begin
                cnt_d = 8'd0;
                if (core_valid_i) begin
                    addr_d  = core_addr_i;
                    wdata_d = core_data_i;
                    we_d    = core_write_i;
                    if ((core_read_i == core_write_i) || (core_addr_i[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = STATE_RESPOND;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (core_addr_i >= IO_BASE) ? STATE_IO_WAIT : STATE_RAM_WAIT;
                    end
                end
            end
            STATE_RAM_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == (we_q ? RAM_WR_LAST : RAM_RD_LAST)) begin
                    rdata_d = we_q ? '0 : ram_data_i;
                    state_d = STATE_RESPOND;
                end
            end
            STATE_IO_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // An ack on the timeout edge still counts as a success.
                if (io_ack_i) begin
                    rdata_d = we_q ? '0 : io_data_i;
                    state_d = STATE_RESPOND;
                end else if (cnt_q == IO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = STATE_RESPOND;
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            state_q <= STATE_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready_o      = (state_q == STATE_IDLE);
    assign core_valid_o = (state_q == STATE_RESPOND);
    assign bus_error_o  = (state_q == STATE_RESPOND) && err_q;
    assign core_data_o  = rdata_q;

    // The RAM enable is the first RAM_WAIT cycle only.
    assign ram_en_o   = (state_q == STATE_RAM_WAIT) && (cnt_q == 8'd0);
    assign ram_we_o   = ram_en_o && we_q;
    assign ram_addr_o = addr_q;
    assign ram_data_o = wdata_q;

    assign io_read_o  = (state_q == STATE_IO_WAIT) && !we_q;
    assign io_write_o = (state_q == STATE_IO_WAIT) && we_q;
    assign io_addr_o  = addr_q;
    assign io_data_o  = wdata_q;

endmodule

// File: doc/w0rm_data_bus_bridge.md
W0RM_DATA_BUS_BRIDGE -- requirements
Module: w0rm_data_bus_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, core/bus data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter RAM_WAIT, default 1 (legal 1..15), RAM read latency in cycles.
REQ-004 SHALL have parameter IO_BASE, default 32'hFFFF_0000; addresses >= IO_BASE select IO, else RAM.
REQ-005 SHALL have parameter TIMEOUT, default 255 (legal 1..255), IO ack timeout in cycles.
REQ-006 SHALL have ports: core_clk  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high.
REQ-007 SHALL have core side: core_addr_i in ADDR_WIDTH; core_data_i in DATA_WIDTH; core_read_i, core_write_i, core_valid_i in 1 (request strobes, single-cycle).
REQ-008 SHALL have core return: core_data_o out DATA_WIDTH read data; core_valid_o out 1 completion pulse; ready_o out 1 idle/accepting; bus_error_o out 1 error pulse.
REQ-009 SHALL have RAM side: ram_en_o out 1; ram_we_o out 1; ram_addr_o out ADDR_WIDTH; ram_data_o out DATA_WIDTH; ram_data_i in DATA_WIDTH (synchronous RAM).
REQ-010 SHALL have IO side: io_read_o, io_write_o out 1; io_addr_o out ADDR_WIDTH; io_data_o out DATA_WIDTH; io_data_i in DATA_WIDTH; io_ack_i in 1.

Function
REQ-011 SHALL implement states IDLE, RAM_WAIT, IO_WAIT, RESPOND; ready_o=1 only in IDLE.
REQ-012 SHALL accept a request at an edge where state=IDLE and core_valid_i=1; core_valid_i outside IDLE ignored, no response.
REQ-013 SHALL register address/data/direction at acceptance; later core input changes have no effect.
REQ-014 SHALL flag error when read and write both 1, both 0, or core_addr_i[1:0]!=0: no RAM/IO strobe, go RESPOND, core_data_o=0.
REQ-015 RAM access: ram_en_o=1 for exactly the one cycle after acceptance, ram_we_o=write, ram_addr_o/ram_data_o = latched values; then RAM_WAIT.
REQ-016 RAM read: core_data_o = ram_data_i sampled RAM_WAIT edges after the ram_en_o cycle ends; core_valid_o rises RAM_WAIT+1 edges after acceptance.
REQ-017 RAM write: core_valid_o rises 2 edges after acceptance, core_data_o=0.
REQ-018 IO access: io_read_o/io_write_o high from acceptance edge until edge sampling io_ack_i=1; io_addr_o/io_data_o stable while strobed.
REQ-019 IO ack: core_data_o = io_data_i (read) or 0 (write) captured on ack edge; core_valid_o high next cycle; ack in the first strobed cycle legal.
REQ-020 IO timeout: 8-bit counter cleared at acceptance, increments each IO_WAIT cycle; at count==TIMEOUT without ack, drop strobes, core_data_o=0, error response.
REQ-021 io_ack_i outside IO_WAIT SHALL be ignored.
REQ-022 RESPOND: core_valid_o=1 for exactly one cycle, bus_error_o=1 same cycle iff error/timeout; then IDLE.
REQ-023 core_data_o SHALL hold last value until next capture.
REQ-024 Back-to-back: new request accepted in cycle after RESPOND (one idle cycle minimum between completions).

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, counter 0, all outputs 0 except ready_o=1, from next cycle.
REQ-026 reset mid-transaction SHALL abort: strobes low next cycle, no core_valid_o pulse for aborted request.
REQ-027 reset SHALL dominate a coincident core_valid_i (request not accepted).

Verification
REQ-028 RAM read 0x0000_0010, RAM_WAIT=1, ram_data_i=0x1234_5678 -> ram_en_o cycle 1, core_valid_o at edge 2, core_data_o=0x1234_5678, bus_error_o=0.
REQ-029 RAM write 0x0000_0020 data 0xCAFE_F00D -> one-cycle ram_en_o=ram_we_o=1 with those values, core_valid_o at edge 2.
REQ-030 IO read 0xFFFF_0004, ack after 3 cycles, io_data_i=0xA5A5_0001 -> io_read_o high 3 cycles, core_data_o=0xA5A5_0001, one pulse.
REQ-031 IO write, no ack, TIMEOUT=4 -> io_write_o drops after 4 cycles, core_valid_o and bus_error_o pulse together, core_data_o=0.
REQ-032 Read at 0x0000_0002, and read+write both set -> no strobes, error pulse with core_data_o=0; core_valid_i while busy -> ignored.
REQ-033 reset asserted during IO_WAIT -> io_read_o low next cycle, ready_o=1, no core_valid_o.
